// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes and load-use hazard detection.
// The E registers capture decode fields; forwarding and hazard outputs are combinational.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic            d_valid,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_rs1_data,
  input  logic [XLEN-1:0] d_rs2_data,
  input  logic [XLEN-1:0] d_imm,
  input  logic [4:0]      d_rs1,
  input  logic [4:0]      d_rs2,
  input  logic [4:0]      d_rd,
  input  logic [3:0]      d_alu_control,
  input  logic [1:0]      d_alu_src_a,
  input  logic            d_alu_src_b,
  input  logic            d_reg_write,
  input  logic            d_mem_write,
  input  logic            d_branch,
  input  logic            d_jump,
  input  logic [1:0]      d_result_src,
  input  logic [4:0]      m_rd,
  input  logic            m_reg_write,
  input  logic [XLEN-1:0] m_alu_result,
  input  logic [4:0]      w_rd,
  input  logic            w_reg_write,
  input  logic [XLEN-1:0] w_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      e_alu_control,
  output logic [XLEN-1:0] e_store_data,
  output logic            e_valid,
  output logic            e_reg_write,
  output logic            e_mem_write,
  output logic            e_branch,
  output logic            e_jump,
  output logic [XLEN-1:0] e_pc,
  output logic [XLEN-1:0] e_imm,
  output logic [4:0]      e_rd,
  output logic [1:0]      e_result_src,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            load_use_stall
);

  localparam logic [3:0] AluSum    = 4'b0000;
  localparam logic [1:0] FwdRf     = 2'b00;
  localparam logic [1:0] FwdWb     = 2'b01;
  localparam logic [1:0] FwdMem    = 2'b10;
  localparam logic [1:0] SrcARs1   = 2'b00;
  localparam logic [1:0] SrcAPc    = 2'b01;
  localparam logic [1:0] SrcAZero  = 2'b10;
  localparam logic [1:0] ResLoad   = 2'b01;

  logic            valid_q, reg_write_q, mem_write_q, branch_q, jump_q, alu_src_b_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [3:0]      alu_control_q;
  logic [1:0]      alu_src_a_q, result_src_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_data_q, rs2_data_q;
  logic [XLEN-1:0] src_a_fwd, src_b_fwd;

  // Reset and flush both load the bubble; flush overrides stall.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      valid_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_write_q   <= 1'b0;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_control_q <= AluSum;
      alu_src_a_q   <= SrcAZero;
      alu_src_b_q   <= 1'b0;
      result_src_q  <= 2'b00;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
    end else if (!stall_e) begin
      valid_q       <= d_valid;
      reg_write_q   <= d_reg_write;
      mem_write_q   <= d_mem_write;
      branch_q      <= d_branch;
      jump_q        <= d_jump;
      rs1_q         <= d_rs1;
      rs2_q         <= d_rs2;
      rd_q          <= d_rd;
      alu_control_q <= d_alu_control;
      alu_src_a_q   <= d_alu_src_a;
      alu_src_b_q   <= d_alu_src_b;
      result_src_q  <= d_result_src;
      pc_q          <= d_pc;
      imm_q         <= d_imm;
      rs1_data_q    <= d_rs1_data;
      rs2_data_q    <= d_rs2_data;
    end
  end

  // MEM is checked first so the younger result wins when both stages match.
  always_comb begin
    fwd_a = FwdRf;
    if (m_reg_write && (m_rd != 5'd0) && (m_rd == rs1_q)) begin
      fwd_a = FwdMem;
    end else if (w_reg_write && (w_rd != 5'd0) && (w_rd == rs1_q)) begin
      fwd_a = FwdWb;
    end
    fwd_b = FwdRf;
    if (m_reg_write && (m_rd != 5'd0) && (m_rd == rs2_q)) begin
      fwd_b = FwdMem;
    end else if (w_reg_write && (w_rd != 5'd0) && (w_rd == rs2_q)) begin
      fwd_b = FwdWb;
    end
  end

  always_comb begin
    src_a_fwd = rs1_data_q;
    case (fwd_a)
      FwdWb:   src_a_fwd = w_result;
      FwdMem:  src_a_fwd = m_alu_result;
      default: src_a_fwd = rs1_data_q;
    endcase
    src_b_fwd = rs2_data_q;
    case (fwd_b)
      FwdWb:   src_b_fwd = w_result;
      FwdMem:  src_b_fwd = m_alu_result;
      default: src_b_fwd = rs2_data_q;
    endcase
    alu_a = '0;
    case (alu_src_a_q)
      SrcARs1: alu_a = src_a_fwd;
      SrcAPc:  alu_a = pc_q;
      default: alu_a = '0;
    endcase
    alu_b = alu_src_b_q ? imm_q : src_b_fwd;
  end

  assign load_use_stall = valid_q && (result_src_q == ResLoad) && (rd_q != 5'd0) &&
                          ((d_rs1 == rd_q) || (d_rs2 == rd_q)) && d_valid;

  assign e_store_data  = src_b_fwd;
  assign e_alu_control = alu_control_q;
  assign e_valid       = valid_q;
  assign e_reg_write   = reg_write_q;
  assign e_mem_write   = mem_write_q;
  assign e_branch      = branch_q;
  assign e_jump        = jump_q;
  assign e_pc          = pc_q;
  assign e_imm         = imm_q;
  assign e_rd          = rd_q;
  assign e_result_src  = result_src_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset bubble, forwarding priority, load-use detection,
// stall/flush behaviour, PC/immediate operand selection and reset during a stall.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e, d_valid;
  logic [31:0] d_pc, d_rs1_data, d_rs2_data, d_imm;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [3:0]  d_alu_control;
  logic [1:0]  d_alu_src_a;
  logic        d_alu_src_b, d_reg_write, d_mem_write, d_branch, d_jump;
  logic [1:0]  d_result_src;
  logic [4:0]  m_rd, w_rd;
  logic        m_reg_write, w_reg_write;
  logic [31:0] m_alu_result, w_result;
  logic [31:0] alu_a, alu_b, e_store_data, e_pc, e_imm;
  logic [3:0]  e_alu_control;
  logic        e_valid, e_reg_write, e_mem_write, e_branch, e_jump;
  logic [4:0]  e_rd;
  logic [1:0]  e_result_src, fwd_a, fwd_b;
  logic        load_use_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .d_valid(d_valid),
    .d_pc(d_pc), .d_rs1_data(d_rs1_data), .d_rs2_data(d_rs2_data), .d_imm(d_imm),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_alu_control(d_alu_control),
    .d_alu_src_a(d_alu_src_a), .d_alu_src_b(d_alu_src_b), .d_reg_write(d_reg_write),
    .d_mem_write(d_mem_write), .d_branch(d_branch), .d_jump(d_jump),
    .d_result_src(d_result_src), .m_rd(m_rd), .m_reg_write(m_reg_write),
    .m_alu_result(m_alu_result), .w_rd(w_rd), .w_reg_write(w_reg_write), .w_result(w_result),
    .alu_a(alu_a), .alu_b(alu_b), .e_alu_control(e_alu_control), .e_store_data(e_store_data),
    .e_valid(e_valid), .e_reg_write(e_reg_write), .e_mem_write(e_mem_write),
    .e_branch(e_branch), .e_jump(e_jump), .e_pc(e_pc), .e_imm(e_imm), .e_rd(e_rd),
    .e_result_src(e_result_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use_stall(load_use_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    d_valid = 0; d_pc = 0; d_rs1_data = 0; d_rs2_data = 0; d_imm = 0;
    d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_alu_control = 0; d_alu_src_a = 0; d_alu_src_b = 0;
    d_reg_write = 0; d_mem_write = 0; d_branch = 0; d_jump = 0; d_result_src = 0;
  endtask

  task automatic clear_fwd();
    m_rd = 0; m_reg_write = 0; m_alu_result = 0; w_rd = 0; w_reg_write = 0; w_result = 0;
  endtask

  initial begin
    reset = 1; stall_e = 0; flush_e = 0;
    clear_d();
    clear_fwd();
    d_valid = 1; d_reg_write = 1; d_pc = 32'hdead; d_alu_control = 4'h7;
    tick();
    reset = 0;
    clear_d();
    chk("rst_valid", {31'd0, e_valid}, 32'd0);
    chk("rst_regw", {31'd0, e_reg_write}, 32'd0);
    chk("rst_aluctl", {28'd0, e_alu_control}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("rst_pc", e_pc, 32'd0);

    // Plain add, no forwarding.
    d_valid = 1; d_rs1 = 5; d_rs2 = 6; d_rs1_data = 32'h10; d_rs2_data = 32'h20;
    d_rd = 8; d_reg_write = 1; d_pc = 32'h40;
    tick();
    chk("add_alu_a", alu_a, 32'h10);
    chk("add_alu_b", alu_b, 32'h20);
    chk("add_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
    chk("add_valid", {31'd0, e_valid}, 32'd1);
    chk("add_rd", {27'd0, e_rd}, 32'd8);
    chk("add_pc", e_pc, 32'h40);

    // Forwarding on rs1 = 3, rs2 = 6.
    d_rs1 = 3; d_rs1_data = 32'h1234;
    tick();
    m_reg_write = 1; m_rd = 3; m_alu_result = 32'hAAAA;
    w_reg_write = 1; w_rd = 3; w_result = 32'hBBBB;
    #1;
    chk("fwd_a_mem", {30'd0, fwd_a}, 32'd2);
    chk("alu_a_mem", alu_a, 32'hAAAA);
    chk("fwd_b_none", {30'd0, fwd_b}, 32'd0);
    m_rd = 4;
    #1;
    chk("fwd_a_wb", {30'd0, fwd_a}, 32'd1);
    chk("alu_a_wb", alu_a, 32'hBBBB);
    w_rd = 6;
    #1;
    chk("fwd_b_wb", {30'd0, fwd_b}, 32'd1);
    chk("alu_b_wb", alu_b, 32'hBBBB);
    chk("alu_a_rf", alu_a, 32'h1234);
    m_rd = 6;
    #1;
    chk("fwd_b_mem", {30'd0, fwd_b}, 32'd2);
    chk("store_mem", e_store_data, 32'hAAAA);
    m_reg_write = 0;
    #1;
    chk("fwd_b_nowr", {30'd0, fwd_b}, 32'd1);
    clear_fwd();

    // Load with rd = 7 in E.
    clear_d();
    d_valid = 1; d_result_src = 2'b01; d_rd = 7; d_reg_write = 1;
    tick();
    d_rs1 = 1; d_rs2 = 7; d_valid = 1;
    #1;
    chk("lu_rs2", {31'd0, load_use_stall}, 32'd1);
    flush_e = 1; stall_e = 1;
    #1;
    chk("lu_indep", {31'd0, load_use_stall}, 32'd1);
    flush_e = 0; stall_e = 0;
    d_valid = 0;
    #1;
    chk("lu_dinv", {31'd0, load_use_stall}, 32'd0);
    d_valid = 1; d_rs1 = 7; d_rs2 = 2;
    #1;
    chk("lu_rs1", {31'd0, load_use_stall}, 32'd1);

    // Load with rd = 0: never a hazard, rs1 = 0 never forwards.
    clear_d();
    d_valid = 1; d_result_src = 2'b01; d_rd = 0;
    tick();
    d_valid = 1; d_rs1 = 0; d_rs2 = 0;
    m_reg_write = 1; m_rd = 0; m_alu_result = 32'h77;
    #1;
    chk("lu_rd0", {31'd0, load_use_stall}, 32'd0);
    chk("fwd_idx0", {28'd0, fwd_a, fwd_b}, 32'd0);
    clear_fwd();

    // Stall for three cycles while D changes, then flush with stall.
    clear_d();
    d_valid = 1; d_pc = 32'h200; d_rs1 = 9; d_rs1_data = 32'h99; d_rs2 = 10;
    d_rs2_data = 32'h77; d_rd = 11; d_alu_control = 4'h3; d_reg_write = 1;
    tick();
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      d_pc = 32'h300 + i; d_rs1_data = 32'h5555 + i; d_rs2_data = 32'h6666;
      d_rd = 5'd12 + 5'(i); d_alu_control = 4'h9; d_valid = 0;
      tick();
    end
    chk("stall_pc", e_pc, 32'h200);
    chk("stall_alu_a", alu_a, 32'h99);
    chk("stall_alu_b", alu_b, 32'h77);
    chk("stall_aluctl", {28'd0, e_alu_control}, 32'h3);
    chk("stall_rd", {27'd0, e_rd}, 32'd11);
    chk("stall_valid", {31'd0, e_valid}, 32'd1);
    flush_e = 1;
    tick();
    flush_e = 0; stall_e = 0;
    chk("flush_valid", {31'd0, e_valid}, 32'd0);
    chk("flush_alu_a", alu_a, 32'd0);
    chk("flush_alu_b", alu_b, 32'd0);
    chk("flush_aluctl", {28'd0, e_alu_control}, 32'd0);
    chk("flush_regw", {31'd0, e_reg_write}, 32'd0);

    // AUIPC-style operands.
    clear_d();
    d_valid = 1; d_alu_src_a = 2'b01; d_alu_src_b = 1; d_pc = 32'h100; d_imm = 32'h1000;
    d_rs2 = 12; d_rs2_data = 32'h22; d_mem_write = 1;
    tick();
    chk("auipc_a", alu_a, 32'h100);
    chk("auipc_b", alu_b, 32'h1000);
    chk("store_rf", e_store_data, 32'h22);
    chk("imm_reg", e_imm, 32'h1000);
    m_reg_write = 1; m_rd = 12; m_alu_result = 32'h55;
    #1;
    chk("store_fwd", e_store_data, 32'h55);
    chk("auipc_b_fwd", alu_b, 32'h1000);
    clear_fwd();

    // Reset while a valid instruction is stalled.
    clear_d();
    d_valid = 1; d_rs1 = 1; d_rd = 4; d_alu_control = 4'h5; d_reg_write = 1;
    tick();
    stall_e = 1;
    tick();
    chk("pre_rst_valid", {31'd0, e_valid}, 32'd1);
    chk("pre_rst_aluctl", {28'd0, e_alu_control}, 32'h5);
    reset = 1;
    tick();
    reset = 0; stall_e = 0;
    chk("mid_rst_valid", {31'd0, e_valid}, 32'd0);
    chk("mid_rst_regw", {31'd0, e_reg_write}, 32'd0);
    chk("mid_rst_aluctl", {28'd0, e_alu_control}, 32'd0);
    chk("mid_rst_rd", {27'd0, e_rd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 stall_e  in  1  hold all E-stage registers.
REQ-005 flush_e  in  1  load a bubble into E-stage registers.
REQ-006 d_valid  in  1  decode-stage instruction valid.
REQ-007 d_pc, d_rs1_data, d_rs2_data, d_imm  in  32 each  decode PC, register-file reads, extended immediate.
REQ-008 d_rs1, d_rs2, d_rd  in  5 each  decode register indices.
REQ-009 d_alu_control  in  4  ALU operation code; same encoding as the ALU control port.
REQ-010 d_alu_src_a  in  2  00 = rs1, 01 = PC, 10 = zero, 11 = zero.
REQ-011 d_alu_src_b  in  1  0 = rs2, 1 = immediate.
REQ-012 d_reg_write, d_mem_write, d_branch, d_jump  in  1 each  decode control.
REQ-013 d_result_src  in  2  00 = ALU, 01 = load, 10 = PC+4.
REQ-014 m_rd  in  5; m_reg_write  in  1; m_alu_result  in  32  MEM-stage forwarding source.
REQ-015 w_rd  in  5; w_reg_write  in  1; w_result  in  32  WB-stage forwarding source.
REQ-016 alu_a, alu_b  out  32 each  ALU operands.
REQ-017 e_alu_control  out  4  registered ALU operation code.
REQ-018 e_store_data  out  32  forwarded rs2 value.
REQ-019 e_valid, e_reg_write, e_mem_write, e_branch, e_jump  out  1 each  registered control.
REQ-020 e_pc, e_imm  out  32 each; e_rd  out  5; e_result_src  out  2  registered fields.
REQ-021 fwd_a, fwd_b  out  2 each  forward select: 00 = register file, 01 = WB, 10 = MEM.
REQ-022 load_use_stall  out  1  request to stall F/D and flush E next cycle.

Function
REQ-023 E registers (all d_* fields, including rs1/rs2 indices) load decode values on each edge when neither stall_e, flush_e nor reset is asserted.
REQ-024 stall_e=1 and flush_e=0: all E registers hold their value.
REQ-025 Flush: a bubble is loaded when flush_e=1, and takes priority over stall_e.
REQ-026 Bubble contents: valid, reg_write, mem_write, branch and jump = 0; rd, rs1 and rs2 = 0; alu_control = SUM; alu_src_a = 10; alu_src_b = 0; result_src = 00; PC, immediate and data = 0.
REQ-027 fwd_a is combinational from the registered E indices: 10 if m_reg_write and m_rd≠0 and m_rd==e_rs1; else 01 if w_reg_write and w_rd≠0 and w_rd==e_rs1; else 00.
REQ-028 fwd_b uses the same rule as fwd_a with e_rs2; on a match with both stages, MEM wins.
REQ-029 srcA_fwd and srcB_fwd are selected by fwd_a and fwd_b from {e_rs1_data or e_rs2_data, w_result, m_alu_result}.
REQ-030 alu_a is selected by e_alu_src_a: srcA_fwd, e_pc, or 0.
REQ-031 alu_b = e_imm when e_alu_src_b = 1; otherwise alu_b = srcB_fwd.
REQ-032 e_store_data = srcB_fwd, regardless of alu_src_b.
REQ-033 Operand path latency: alu_a and alu_b are valid in the same cycle the instruction occupies E, with zero added cycles.
REQ-034 load_use_stall = e_valid & (e_result_src == 01) & e_rd≠0 & ((d_rs1 == e_rd) | (d_rs2 == e_rd)) & d_valid; it is combinational.
REQ-035 load_use_stall is independent of the flush_e and stall_e inputs; the hazard controller arbitrates.
REQ-036 Index 0 never forwards and never raises load_use_stall.
REQ-037 Forwarding inputs have no effect on the E registers; they affect only combinational outputs.

Reset
REQ-038 reset=1 at a rising edge loads the bubble of REQ-026, regardless of stall_e and flush_e.
REQ-039 Reset mid-stall discards the held instruction.
REQ-040 With the E registers in the bubble state, outputs are e_valid=0, alu_a=0, alu_b=0 and fwd_a=fwd_b=00, provided no forwarding match exists.
REQ-041 Reset is evaluated only at clock edges; combinational outputs follow register state.

Verification
REQ-042 Scenario: after reset, the bench SHALL load an add with rs1=5 (0x10) and rs2=6 (0x20), with no forwarding matches. Required response next cycle: alu_a=0x10, alu_b=0x20, fwd_a=fwd_b=00, e_valid=1.
REQ-043 Scenario: E has rs1=3, with MEM (rd=3, 0xAAAA) and WB (rd=3, 0xBBBB) both writing. Required response: fwd_a=10, alu_a=0xAAAA. With MEM rd changed to 4: fwd_a=01, alu_a=0xBBBB.
REQ-044 Scenario: E holds a load with rd=7, D has rs2=7, d_valid=1. Required response: load_use_stall=1. With rd=0 instead: load_use_stall=0.
REQ-045 Scenario: stall_e=1 for 3 cycles while d_* change. Required response: E outputs unchanged. Then flush_e=1 together with stall_e=1: bubble loaded, e_valid=0.
REQ-046 Scenario: AUIPC-style operands, alu_src_a=01 and alu_src_b=1, with d_pc=0x100 and d_imm=0x1000. Required response: alu_a=0x100, alu_b=0x1000. With rs2 forwarded from MEM at 0x55: e_store_data=0x55.
REQ-047 Scenario: assert reset while a valid instruction is stalled in E. Required response: next cycle e_valid=0, e_reg_write=0, e_alu_control=SUM.
